// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer sharing the single-port `mem` between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed data-first priority.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;        // 1 = data port owns the current access
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic          i_err_q, i_err_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_err_q, d_err_d;

    logic          grant_data;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;
    logic          sel_misaligned;
    logic [DW-1:0] rd_capture;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;               // 1 = data port was granted last

    assign grant_data = d_req & (~i_req | ~last_q);
`else
    assign grant_data = d_req;
`endif

    assign sel_addr       = grant_data ? d_addr : i_addr;
    assign sel_wdata      = grant_data ? d_wdata : '0;
    assign sel_we         = grant_data & d_we;
    assign sel_misaligned = (sel_addr[1:0] != 2'b00);

    // Errors and stores both return zero read data.
    assign rd_capture = (err_q | we_q) ? '0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_req | d_req) begin
                    sel_d       = grant_data;
                    we_d        = sel_we;
                    err_d       = sel_misaligned;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_read_d  = ~sel_misaligned & ~sel_we;
                    mem_write_d = ~sel_misaligned & sel_we;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d      = grant_data;
`endif
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (sel_q) begin
                    d_rdata_d = rd_capture;
                    d_err_d   = err_q;
                end else begin
                    i_rdata_d = rd_capture;
                    i_err_d   = err_q;
                end
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign i_ack     = (state_q == StResp) & ~sel_q;
    assign d_ack     = (state_q == StResp) & sel_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule
